// File: rtl/longop_sequencer.sv
// Launch/wait/hold sequencer for the multi-cycle MUL/DIV and FPU units in EX.
// Launches one unit at a time, stalls the pipe until writeback takes the result.
module longop_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        issue_valid_i,
    input  logic        muldiv_start_i,
    input  logic        muldiv_sel_i,
    input  logic [1:0]  op_md_i,
    input  logic        fpu_start_i,
    input  logic [4:0]  fpu_func_i,
    input  logic [2:0]  fpu_rm_i,
    input  logic [4:0]  rd_i,
    input  logic        rb_sel_i,
    input  logic        flush_i,
    input  logic        md_done_i,
    input  logic [31:0] md_result_i,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    input  logic        wb_ready_i,
    output logic        md_start_o,
    output logic        md_sel_o,
    output logic [1:0]  md_op_o,
    output logic        fpu_start_o,
    output logic [4:0]  fpu_func_o,
    output logic [2:0]  fpu_rm_o,
    output logic        kill_o,
    output logic        stall_o,
    output logic        busy_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic [4:0]  result_rd_o,
    output logic        result_rb_sel_o,
    output logic [4:0]  fflags_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        HOLD
    } state_t;

    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic              unit_fp_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              md_sel_q;
    logic [1:0]        md_op_q;
    logic [4:0]        fpu_func_q;
    logic [2:0]        fpu_rm_q;
    logic [4:0]        rd_q;
    logic              rb_sel_q;
    logic [31:0]       result_q;
    logic [4:0]        flags_q;

    logic req;
    logic unit_done;
    logic load_issue;
    logic load_result;
    logic cnt_clr;
    logic cnt_inc;

    assign unit_done = unit_fp_q ? fpu_done_i : md_done_i;

    // Next state, launch/abort pulses and register load enables.
    always_comb begin
        state_d        = state_q;
        req            = 1'b0;
        load_issue     = 1'b0;
        load_result    = 1'b0;
        cnt_clr        = 1'b0;
        cnt_inc        = 1'b0;
        md_start_o     = 1'b0;
        fpu_start_o    = 1'b0;
        kill_o         = 1'b0;
        timeout_o      = 1'b0;
        stall_o        = 1'b0;
        busy_o         = 1'b0;
        result_valid_o = 1'b0;
        if (!reset_i) begin
            busy_o = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    req = issue_valid_i & (muldiv_start_i | fpu_start_i)
                        & ~flush_i;
                    if (req) begin
                        load_issue = 1'b1;
                        state_d    = LAUNCH;
                    end
                    stall_o = req;
                end
                LAUNCH: begin
                    stall_o = 1'b1;
                    cnt_clr = 1'b1;
                    if (flush_i) begin
                        kill_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        md_start_o  = ~unit_fp_q;
                        fpu_start_o = unit_fp_q;
                        state_d     = WAIT;
                    end
                end
                WAIT: begin
                    stall_o = 1'b1;
                    if (flush_i) begin
                        kill_o  = 1'b1;
                        state_d = IDLE;
                    end else if (unit_done) begin
                        load_result = 1'b1;
                        state_d     = HOLD;
                    end else if (WD_EN && cnt_q == CNT_LAST) begin
                        kill_o    = 1'b1;
                        timeout_o = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                HOLD: begin
                    result_valid_o = 1'b1;
                    stall_o        = ~wb_ready_i;
                    if (flush_i || wb_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, watchdog counter and latched operation/result context.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            unit_fp_q  <= 1'b0;
            cnt_q      <= '0;
            md_sel_q   <= 1'b0;
            md_op_q    <= '0;
            fpu_func_q <= '0;
            fpu_rm_q   <= '0;
            rd_q       <= '0;
            rb_sel_q   <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_issue) begin
                unit_fp_q  <= ~muldiv_start_i;
                md_sel_q   <= muldiv_sel_i;
                md_op_q    <= op_md_i;
                fpu_func_q <= fpu_func_i;
                fpu_rm_q   <= fpu_rm_i;
                rd_q       <= rd_i;
                rb_sel_q   <= rb_sel_i;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (load_result) begin
                result_q <= unit_fp_q ? fpu_result_i : md_result_i;
                flags_q  <= unit_fp_q ? fpu_flags_i : 5'd0;
            end
        end
    end

    assign md_sel_o        = md_sel_q;
    assign md_op_o         = md_op_q;
    assign fpu_func_o      = fpu_func_q;
    assign fpu_rm_o        = fpu_rm_q;
    assign result_o        = result_q;
    assign result_rd_o     = rd_q;
    assign result_rb_sel_o = rb_sel_q;
    assign fflags_o        = flags_q;

endmodule
